char_buf_ctrl: RTL and testbench

//  Controller for the 16x16 on-screen character buffer read by the text-rect draw stages.
//  - Arbitrates character writes from two requesters (menu/game logic) over valid/ready.
//  - Runs a clear sweep that fills the buffer with CLR_CHAR, at reset and on request.
//  - Serves the draw stage's char_xy lookups with a 1-cycle registered char code.

---
 rtl/char_buf_ctrl_pkg.sv | 16 +
 rtl/char_buf_ctrl_if.sv | 30 +++
 rtl/char_buf_ram.sv | 42 ++++
 rtl/char_buf_ctrl.sv | 128 ++++++++++++
 tb/tb_char_buf_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/char_buf_ctrl_pkg.sv
// Shared constants, FSM state type and write-port payload for the character buffer controller.
package char_buf_ctrl_pkg;

    localparam int unsigned CHAR_BUF_ADDR_W = 8;
    localparam int unsigned CHAR_BUF_DATA_W = 8;
    localparam int unsigned CHAR_BUF_DEPTH  = 1 << CHAR_BUF_ADDR_W;
    localparam logic [CHAR_BUF_DATA_W-1:0] CHAR_CLR_CODE = 8'h20;

    typedef enum logic {CB_IDLE, CB_CLEAR} char_buf_state_t;

    typedef struct packed {
        logic [CHAR_BUF_ADDR_W-1:0] addr;
        logic [CHAR_BUF_DATA_W-1:0] data;
    } char_wr_t;

endpackage

// File: rtl/char_buf_ctrl_if.sv
// Requester handshakes, clear control and draw-stage lookup for the character buffer.
interface char_buf_ctrl_if;
    import char_buf_ctrl_pkg::*;

    logic                       req0_valid;
    logic [CHAR_BUF_ADDR_W-1:0] req0_addr;
    logic [CHAR_BUF_DATA_W-1:0] req0_data;
    logic                       req0_ready;
    logic                       req1_valid;
    logic [CHAR_BUF_ADDR_W-1:0] req1_addr;
    logic [CHAR_BUF_DATA_W-1:0] req1_data;
    logic                       req1_ready;
    logic                       clr_req;
    logic                       busy;
    logic [CHAR_BUF_ADDR_W-1:0] char_xy;
    logic [CHAR_BUF_DATA_W-1:0] char_code;

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
               clr_req, char_xy,
        input  req0_ready, req1_ready, busy, char_code
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
               clr_req, char_xy,
        output req0_ready, req1_ready, busy, char_code
    );

endinterface

// File: rtl/char_buf_ram.sv
// Simple dual-port buffer RAM: one sync write port, one registered read-first read port.
module char_buf_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Contents are never reset; the controller's clear sweep initialises them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem_q[raddr];
    end

    // Sampling before the same-edge write lands gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/char_buf_ctrl.sv
// Character buffer controller: clear sweep FSM, two-requester write arbiter, read port.
// Define CHAR_BUF_PRIO_EN for fixed priority (req0 over req1); default is round-robin.
module char_buf_ctrl
    import char_buf_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    char_buf_ctrl_if.slave  bus
);

    localparam int unsigned ADDR_W = CHAR_BUF_ADDR_W;
    localparam int unsigned DATA_W = CHAR_BUF_DATA_W;
    localparam int unsigned DEPTH  = CHAR_BUF_DEPTH;

    char_buf_state_t   state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              gnt0, gnt1;
    logic              wr_en;
    char_wr_t          wr;

`ifndef CHAR_BUF_PRIO_EN
    logic              rr_last_q, rr_last_d;
`endif

    // Grants only in IDLE with no clear request; reset drops anything pending.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && (state_q == CB_IDLE) && !bus.clr_req) begin
`ifdef CHAR_BUF_PRIO_EN
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid && !bus.req0_valid;
`else
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = rr_last_q;
                gnt1 = !rr_last_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
`endif
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.busy       = (state_q == CB_CLEAR);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_en      = 1'b0;
        wr         = '0;
        case (state_q)
            CB_CLEAR: begin
                wr_en      = 1'b1;
                wr.addr    = clr_addr_q;
                wr.data    = CHAR_CLR_CODE;
                clr_addr_d = ADDR_W'(clr_addr_q + 1'b1);
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = CB_IDLE;
                end
            end
            CB_IDLE: begin
                if (bus.clr_req) begin
                    state_d    = CB_CLEAR;
                    clr_addr_d = '0;
                end else if (gnt0) begin
                    wr_en   = 1'b1;
                    wr.addr = bus.req0_addr;
                    wr.data = bus.req0_data;
                end else if (gnt1) begin
                    wr_en   = 1'b1;
                    wr.addr = bus.req1_addr;
                    wr.data = bus.req1_data;
                end
            end
            default: begin
                state_d    = CB_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

`ifndef CHAR_BUF_PRIO_EN
    // Last-served marker moves only on a completed transfer.
    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt0) begin
            rr_last_d = 1'b0;
        end else if (gnt1) begin
            rr_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CB_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    char_buf_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr.addr),
        .wdata (wr.data),
        .raddr (bus.char_xy),
        .rdata (bus.char_code)
    );

endmodule

// File: tb/tb_char_buf_ctrl.sv
// Directed bench for char_buf_ctrl with a cycle model and a read-data scoreboard.
module tb_char_buf_ctrl;
    import char_buf_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    char_buf_ctrl_if bus ();

    char_buf_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m   [256];
    bit         known_m [256];
    bit         m_clear;
    int         m_clr_addr;
    bit         m_rr;
    bit         exp_r0, exp_r1;
    logic [7:0] rd_q [$];
    logic [7:0] d0, d1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already driven; check readys/busy, then the registered read.
    task automatic step();
        bit         pushed;
        logic [7:0] exp_rd;
        @(negedge clk);
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        if (!m_clear && !bus.clr_req) begin
`ifdef CHAR_BUF_PRIO_EN
            exp_r0 = bus.req0_valid;
            exp_r1 = bus.req1_valid && !bus.req0_valid;
`else
            if (bus.req0_valid && bus.req1_valid) begin
                if (m_rr) exp_r0 = 1'b1;
                else      exp_r1 = 1'b1;
            end else begin
                exp_r0 = bus.req0_valid;
                exp_r1 = bus.req1_valid;
            end
`endif
        end
        chk("busy", 32'(bus.busy), 32'(m_clear));
        chk("req0_ready", 32'(bus.req0_ready), 32'(exp_r0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(exp_r1));
        pushed = known_m[bus.char_xy];
        if (pushed) rd_q.push_back(mem_m[bus.char_xy]);
        @(posedge clk);
        if (m_clear) begin
            mem_m[m_clr_addr]   = 8'h20;
            known_m[m_clr_addr] = 1'b1;
            if (m_clr_addr == 255) m_clear = 1'b0;
            m_clr_addr++;
        end else if (bus.clr_req) begin
            m_clear    = 1'b1;
            m_clr_addr = 0;
        end else if (exp_r0) begin
            mem_m[bus.req0_addr]   = bus.req0_data;
            known_m[bus.req0_addr] = 1'b1;
            m_rr = 1'b0;
        end else if (exp_r1) begin
            mem_m[bus.req1_addr]   = bus.req1_data;
            known_m[bus.req1_addr] = 1'b1;
            m_rr = 1'b1;
        end
        #1;
        if (pushed) begin
            exp_rd = rd_q.pop_front();
            chk("char_code", 32'(bus.char_code), 32'(exp_rd));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.clr_req    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear    = 1'b1;
        m_clr_addr = 0;
        m_rr       = 1'b1;
        rd_q.delete();
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_char_code", 32'(bus.char_code), 32'd0);
        chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) known_m[i] = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        bus.clr_req    = 1'b0;
        bus.char_xy    = '0;

        // Power-up sweep, then read back every cell.
        do_reset();
        repeat (256) step();
        for (int i = 0; i < 256; i++) begin
            bus.char_xy = 8'(i);
            step();
        end

        // Single write from requester 0, then read it back.
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h12;
        bus.req0_data  = 8'h41;
        step();
        bus.req0_valid = 1'b0;
        bus.char_xy    = 8'h12;
        step();

        // Both requesters streaming; data only advances after acceptance.
        d0 = 8'hA0;
        d1 = 8'hB0;
        bus.req0_addr  = 8'h00;
        bus.req1_addr  = 8'h01;
        bus.req0_data  = d0;
        bus.req1_data  = d1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (exp_r0) begin d0 = 8'(d0 + 1); bus.req0_data = d0; end
            if (exp_r1) begin d1 = 8'(d1 + 1); bus.req1_data = d1; end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.char_xy    = 8'h00;
        step();
        bus.char_xy    = 8'h01;
        step();

        // Clear request beats a simultaneous valid; req0 waits out the sweep.
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h05;
        bus.req0_data  = 8'h77;
        bus.clr_req    = 1'b1;
        bus.char_xy    = 8'h12;
        step();
        bus.clr_req = 1'b0;
        repeat (257) step();
        bus.req0_valid = 1'b0;
        bus.char_xy    = 8'h05;
        step();

        // Same-address write and read: old value first, new value next cycle.
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h30;
        bus.req0_data  = 8'h55;
        bus.char_xy    = 8'h30;
        step();
        bus.req0_valid = 1'b0;
        step();

        // Both valid for four cycles with fixed payloads.
        bus.req0_addr  = 8'h40;
        bus.req0_data  = 8'h61;
        bus.req1_addr  = 8'h41;
        bus.req1_data  = 8'h62;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (4) step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.char_xy    = 8'h40;
        step();
        bus.char_xy    = 8'h41;
        step();

        // Reset in the middle of a sweep restarts it from cell 0.
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        repeat (10) step();
        do_reset();
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 8'h22;
        bus.req1_data  = 8'h5A;
        repeat (257) step();
        bus.req1_valid = 1'b0;
        bus.char_xy    = 8'h22;
        step();
        bus.char_xy    = 8'h00;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
